// File: rtl/instr_decode_stage.sv
// Decode-stage front end: 2-entry skid FIFO between fetch and decode.
// Opcodes are classified into the immediate-format code on the way in.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [2:0]      id_ExtOp,
    output logic            id_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [2:0]      ext_op;
        logic            illegal;
    } entry_t;

    entry_t     r_mem [DEPTH];
    logic       r_rd;
    logic       r_wr;
    logic [1:0] r_cnt;

    logic       w_push;
    logic       w_pop;
    logic [2:0] w_ext;
    logic       w_ill;
    entry_t     w_head;

    always_comb begin
        w_ext = 3'b111;
        w_ill = 1'b0;
        case (if_instr[6:0])
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011: w_ext = 3'b000;
            7'b0110111, 7'b0010111: w_ext = 3'b001;
            7'b0100011:             w_ext = 3'b010;
            7'b1100011:             w_ext = 3'b011;
            7'b1101111:             w_ext = 3'b100;
            7'b0110011:             w_ext = 3'b111;
            default:                w_ill = 1'b1;
        endcase
    end

    // if_ready comes only from the registered count, so there is no id_ready -> if_ready path
    assign if_ready = (r_cnt != 2'd2);
    assign id_valid = (r_cnt != 2'd0);
    assign w_push   = if_valid & if_ready & ~flush;
    assign w_pop    = id_valid & id_ready & ~flush;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= '{pc: if_pc, instr: if_instr, ext_op: w_ext, illegal: w_ill};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
        end else if (flush) begin
            r_cnt <= 2'd0;
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
        end else begin
            if (w_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign w_head     = r_mem[r_rd];
    assign id_pc      = id_valid ? w_head.pc      : '0;
    assign id_instr   = id_valid ? w_head.instr   : '0;
    assign id_ExtOp   = id_valid ? w_head.ext_op  : 3'b111;
    assign id_illegal = id_valid ? w_head.illegal : 1'b0;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: reset, formats, backpressure,
// pointer wrap under steady push/pop, and flush.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  id_ExtOp;
    logic        id_illegal;

    int n_chk = 0;
    int n_err = 0;

    instr_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_ExtOp   (id_ExtOp),
        .id_illegal (id_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs are changed only after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".vld"}, {31'd0, id_valid}, 32'd0);
        chk({tag, ".rdy"}, {31'd0, if_ready}, 32'd1);
        chk({tag, ".ext"}, {29'd0, id_ExtOp}, 32'd7);
        chk({tag, ".ill"}, {31'd0, id_illegal}, 32'd0);
        chk({tag, ".pc"},  id_pc, 32'd0);
        chk({tag, ".ins"}, id_instr, 32'd0);
    endtask

    logic [31:0] fmt_instr [6] = '{32'h12345037, 32'h00112423, 32'hFE000EE3,
                                   32'h0080006F, 32'h002081B3, 32'hFFFFFFFF};
    logic [2:0]  fmt_ext   [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b111};
    logic        fmt_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        // asynchronous reset asserted mid-cycle
        #3 rst = 1'b1;
        #1 chk_idle("rst_async");
        step();
        step();
        rst = 1'b0;
        step();
        chk_idle("rst_rel");

        // single pass
        if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h00500093; id_ready = 1'b1;
        step();
        if_valid = 1'b0;
        chk("sp.vld", {31'd0, id_valid}, 32'd1);
        chk("sp.pc",  id_pc, 32'h100);
        chk("sp.ins", id_instr, 32'h00500093);
        chk("sp.ext", {29'd0, id_ExtOp}, 32'd0);
        chk("sp.ill", {31'd0, id_illegal}, 32'd0);
        step();
        chk("sp.empty", {31'd0, id_valid}, 32'd0);

        // format coverage, streamed at full rate
        for (int k = 0; k < 6; k++) begin
            if_valid = 1'b1; if_pc = 32'h400 + 32'(k * 4); if_instr = fmt_instr[k];
            step();
            chk($sformatf("fmt%0d.ins", k), id_instr, fmt_instr[k]);
            chk($sformatf("fmt%0d.ext", k), {29'd0, id_ExtOp}, {29'd0, fmt_ext[k]});
            chk($sformatf("fmt%0d.ill", k), {31'd0, id_illegal}, {31'd0, fmt_ill[k]});
        end
        if_valid = 1'b0;
        step();
        chk("fmt.empty", {31'd0, id_valid}, 32'd0);

        // backpressure and full
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hA00; if_instr = 32'h00100093;
        step();
        chk("bp.rdyA", {31'd0, if_ready}, 32'd1);
        if_pc = 32'hB00; if_instr = 32'h00200093;
        step();
        chk("bp.full", {31'd0, if_ready}, 32'd0);
        if_pc = 32'hC00; if_instr = 32'h00300093;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp.hold%0d.pc", k), id_pc, 32'hA00);
            chk($sformatf("bp.hold%0d.rdy", k), {31'd0, if_ready}, 32'd0);
        end
        id_ready = 1'b1;
        step();
        chk("bp.B", id_pc, 32'hB00);
        chk("bp.rdy", {31'd0, if_ready}, 32'd1);
        step();
        if_valid = 1'b0;
        chk("bp.C", id_pc, 32'hC00);
        chk("bp.Cins", id_instr, 32'h00300093);
        step();
        chk("bp.empty", {31'd0, id_valid}, 32'd0);

        // simultaneous push/pop at count 1 across pointer wrap
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h1000; if_instr = 32'h00000013;
        step();
        chk("pp.X0", id_pc, 32'h1000);
        id_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if_pc = 32'h1000 + 32'(k * 4);
            if_instr = 32'h00000013 | (32'(k) << 20);
            step();
            chk($sformatf("pp.X%0d.pc", k), id_pc, 32'h1000 + 32'(k * 4));
            chk($sformatf("pp.X%0d.rdy", k), {31'd0, if_ready}, 32'd1);
        end
        if_valid = 1'b0;
        step();
        chk("pp.empty", {31'd0, id_valid}, 32'd0);

        // flush with full buffer and a beat on the input
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hF100; if_instr = 32'h00100093;
        step();
        if_pc = 32'hF200;
        step();
        chk("fl.full", {31'd0, if_ready}, 32'd0);
        if_pc = 32'hF300; flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        chk("fl.vld", {31'd0, id_valid}, 32'd0);
        chk("fl.rdy", {31'd0, if_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fl.gone%0d", k), {31'd0, id_valid}, 32'd0);
        end

        // reset mid-operation drops buffered entries
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hE000; if_instr = 32'h00100093;
        step();
        if_valid = 1'b0;
        chk("rm.pre", {31'd0, id_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_idle("rm.async");
        step();
        rst = 1'b0;
        step();
        chk_idle("rm.after");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
